// File: rtl/flag_pkg.sv
// Shared flag types, condition codes and the branch-condition evaluator
// used by the flag unit and its simulation models.
package flag_pkg;

    typedef struct packed {
        logic s;
        logic c;
        logic o;
        logic z;
    } flags_t;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_Z  = 4'd1,
        COND_NZ = 4'd2,
        COND_C  = 4'd3,
        COND_NC = 4'd4,
        COND_S  = 4'd5,
        COND_NS = 4'd6,
        COND_O  = 4'd7,
        COND_NO = 4'd8,
        COND_GT = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_LE = 4'd12,
        COND_HI = 4'd13,
        COND_LS = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    function automatic logic eval_cond(input flags_t f, input cond_e c);
        logic r;
        case (c)
            COND_AL: r = 1'b1;
            COND_Z:  r = f.z;
            COND_NZ: r = ~f.z;
            COND_C:  r = f.c;
            COND_NC: r = ~f.c;
            COND_S:  r = f.s;
            COND_NS: r = ~f.s;
            COND_O:  r = f.o;
            COND_NO: r = ~f.o;
            COND_GT: r = ~f.z & (f.s == f.o);
            COND_GE: r = (f.s == f.o);
            COND_LT: r = (f.s != f.o);
            COND_LE: r = f.z | (f.s != f.o);
            COND_HI: r = f.c & ~f.z;
            COND_LS: r = ~f.c | f.z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag vectors for interrupt/CALL save-restore, with a sticky
// error for overflow, underflow and simultaneous push/pop.
module flag_stack
    import flag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  flags_t        din,
    output flags_t        top,
    output logic          pop_ok,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t mem [DEPTH];
    logic   push_ok;
    logic   err_evt;

    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign err_evt = (push & pop) | (push & full) | (pop & empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            err   <= 1'b0;
        end else begin
            if (push_ok)
                depth <= depth + DW'(1);
            else if (pop_ok)
                depth <= depth - DW'(1);
            // a fresh error outranks a same-cycle clear
            if (err_evt)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end

    // contents are don't-care after reset, so no reset on the storage
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[IW'(depth)] <= din;
    end

    assign top = mem[IW'(depth - DW'(1))];

endmodule

// File: rtl/flag_unit.sv
// Z/O/C/S flag register with save stack, bus write and branch-condition
// evaluation. Optional FLAG_UNIT_ZCHAIN_EN enables chained multi-byte zero.
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 cmp_in,
    input  logic                             we,
    input  logic                             overflow,
    input  logic                             carry,
    input  logic                             zchain,
    input  logic                             flags_wr,
    input  logic [3:0]                       flags_din,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clr_err,
    input  logic [3:0]                       cond,
    output logic                             cond_true,
    output logic                             zflag,
    output logic                             oflag,
    output logic                             cflag,
    output logic                             sflag,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    flags_t flags_q;
    flags_t flags_d;
    flags_t stack_top;
    logic   pop_ok;
    logic   z_new;

`ifdef FLAG_UNIT_ZCHAIN_EN
    assign z_new = (cmp_in == '0) & (~zchain | flags_q.z);
`else
    logic unused_zchain;
    assign unused_zchain = zchain;
    assign z_new         = (cmp_in == '0);
`endif

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clr_err (clr_err),
        .din     (flags_q),
        .top     (stack_top),
        .pop_ok  (pop_ok),
        .depth   (depth),
        .full    (stack_full),
        .empty   (stack_empty),
        .err     (stack_err)
    );

    always_comb begin
        flags_d = flags_q;
        if (pop_ok)
            flags_d = stack_top;
        else if (flags_wr)
            flags_d = flags_t'(flags_din);
        else if (we)
            flags_d = {cmp_in[WIDTH-1], carry, overflow, z_new};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= '0;
        else
            flags_q <= flags_d;
    end

    assign cond_true = eval_cond(flags_q, cond_e'(cond));
    assign zflag     = flags_q.z;
    assign oflag     = flags_q.o;
    assign cflag     = flags_q.c;
    assign sflag     = flags_q.s;

endmodule
